// File: rtl/pix_pair_packer_pkg.sv
// pix_pair_packer_pkg: widths, state encoding and defaults shared by the pixel pair packer.
package pix_pair_packer_pkg;

    localparam int PIX_W           = 18;
    localparam int PAIR_W          = 36;
    localparam int ADDR_W          = 19;
    localparam int DEF_FRAME_WORDS = 172800;

    typedef enum logic [1:0] {
        IDLE,
        EVEN,
        HALF,
        FULL
    } state_t;

endpackage

// File: rtl/pix_pair_packer.sv
// pix_pair_packer: packs RGB666 pixels into 36-bit pairs with a ZBT word address per pair.
module pix_pair_packer
    import pix_pair_packer_pkg::*;
#(
    parameter int               FRAME_WORDS = DEF_FRAME_WORDS,
    parameter logic [PIX_W-1:0] PAD_PIXEL   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              line_end,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic [PAIR_W-1:0] two_pixel_vals,
    output logic [ADDR_W-1:0] write_addr,
    output logic              pair_valid,
    output logic              frame_done,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_WORDS - 1);

    state_t            state, state_n, cur;
    logic [ADDR_W-1:0] cnt, base;
    logic [PIX_W-1:0]  held, first;
    logic              take, pair_hit, pad, emit, last;

    // frame_start restarts the frame before the same-cycle pixel is considered
    always_comb begin
        cur      = frame_start ? EVEN : state;
        base     = frame_start ? '0 : cnt;
        take     = pix_valid && cur == EVEN;
        pair_hit = pix_valid && cur == HALF;
        pad      = line_end && (take || (cur == HALF && !pix_valid));
        emit     = pair_hit || pad;
        first    = take ? pix_data : held;
        last     = base == LAST;
        state_n  = emit ? (last ? FULL : EVEN) : (take ? HALF : cur);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            two_pixel_vals <= '0;
            write_addr     <= '0;
            pair_valid     <= 1'b0;
            frame_done     <= 1'b0;
            overrun        <= 1'b0;
            cnt            <= '0;
            held           <= '0;
        end else begin
            pair_valid <= emit;
            frame_done <= emit && last;
            cnt        <= emit ? base + 1'b1 : base;
            overrun    <= overrun | (state == FULL && !frame_start && pix_valid);
            if (take)
                held <= pix_data;
            if (emit) begin
                two_pixel_vals <= pair_hit ? {held, pix_data} : {first, PAD_PIXEL};
                write_addr     <= base;
            end
        end
    end

endmodule

// File: tb/tb_pix_pair_packer.sv
// tb_pix_pair_packer: directed stimulus against a line/frame-level pixel queue model.
module tb_pix_pair_packer;
    import pix_pair_packer_pkg::*;

    localparam int FW = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0, frame_start = 1'b0, line_end = 1'b0, pix_valid = 1'b0;
    logic [PIX_W-1:0]  pix_data = '0;
    logic [PAIR_W-1:0] two_pixel_vals;
    logic [ADDR_W-1:0] write_addr;
    logic              pair_valid, frame_done, overrun;

    pix_pair_packer #(.FRAME_WORDS(FW)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .line_end(line_end),
        .pix_valid(pix_valid), .pix_data(pix_data), .two_pixel_vals(two_pixel_vals),
        .write_addr(write_addr), .pair_valid(pair_valid), .frame_done(frame_done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [PAIR_W-1:0] exp_pair;
    logic [ADDR_W-1:0] exp_addr;
    logic exp_pv, exp_fd, exp_ovr;
    bit armed = 0, active = 0, full = 0;
    logic [PIX_W-1:0] q[$];
    int cnt = 0;

    task automatic chk(input string name, input logic [PAIR_W-1:0] act, input logic [PAIR_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void emit(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        exp_pair = {a, b};
        exp_addr = ADDR_W'(cnt);
        exp_pv   = 1'b1;
        if (cnt == FW - 1) begin
            exp_fd = 1'b1;
            full   = 1;
        end
        cnt++;
    endfunction

    task automatic step(input logic r, input logic fs, input logic le, input logic pv,
                        input logic [PIX_W-1:0] pd);
        @(negedge clk);
        reset = r; frame_start = fs; line_end = le; pix_valid = pv; pix_data = pd;
        @(posedge clk);
        exp_pv = 1'b0;
        exp_fd = 1'b0;
        if (r) begin
            exp_pair = '0; exp_addr = '0; exp_ovr = 1'b0;
            active = 0; full = 0; q.delete(); cnt = 0; armed = 1;
        end else begin
            if (full && pv && !fs) exp_ovr = 1'b1;
            if (fs) begin
                active = 1; full = 0; q.delete(); cnt = 0;
            end
            if (active && !full) begin
                if (pv) begin
                    q.push_back(pd);
                    if (q.size() == 2) begin
                        emit(q[0], q[1]);
                        q.delete();
                    end
                end
                if (le && q.size() == 1) begin
                    emit(q[0], '0);
                    q.delete();
                end
            end
        end
    endtask

    task automatic px(input logic [PIX_W-1:0] d);
        step(0, 0, 0, 1, d);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("pair_valid", PAIR_W'(pair_valid), PAIR_W'(exp_pv));
            chk("frame_done", PAIR_W'(frame_done), PAIR_W'(exp_fd));
            chk("overrun", PAIR_W'(overrun), PAIR_W'(exp_ovr));
            chk("two_pixel_vals", two_pixel_vals, exp_pair);
            chk("write_addr", PAIR_W'(write_addr), PAIR_W'(exp_addr));
        end
    end

    initial begin
        step(1, 0, 0, 0, '0);
        #2 chk("lit_reset_vals", two_pixel_vals, 36'h0);
        chk("lit_reset_flags", {pair_valid, frame_done, overrun}, 36'h0);
        px(18'h11111);
        step(0, 0, 1, 0, '0);
        px(18'h22222);
        step(0, 0, 1, 1, 18'h33333);
        idle();
        #2 chk("lit_idle_no_pair", PAIR_W'(pair_valid), 36'h0);
        chk("lit_idle_addr", PAIR_W'(write_addr), 36'h0);

        step(0, 1, 0, 0, '0);
        px(18'h3FFFF);
        px(18'h00001);
        #2 chk("lit_first_pv", PAIR_W'(pair_valid), 36'h1);
        chk("lit_first_pair", two_pixel_vals, 36'hFFFFC0001);
        chk("lit_first_addr", PAIR_W'(write_addr), 36'h0);
        idle();
        #2 chk("lit_first_pv_drop", PAIR_W'(pair_valid), 36'h0);

        step(0, 1, 0, 0, '0);
        px(18'h2A5A5);
        px(18'h15A5A);
        #2 chk("lit_ab_pair", two_pixel_vals, 36'hA96955A5A);
        px(18'h0F0F0);
        step(0, 0, 1, 0, '0);
        #2 chk("lit_pad_pair", two_pixel_vals, 36'h3C3C00000);
        chk("lit_pad_addr", PAIR_W'(write_addr), 36'h1);
        px(18'h00AAA);
        px(18'h00555);
        #2 chk("lit_next_line_addr", PAIR_W'(write_addr), 36'h2);
        step(0, 0, 1, 0, '0);
        idle();

        step(0, 1, 0, 1, 18'h01234);
        step(0, 0, 1, 1, 18'h04321);
        #2 chk("lit_le_pair_addr", PAIR_W'(write_addr), 36'h0);
        idle();
        #2 chk("lit_le_no_pad", PAIR_W'(pair_valid), 36'h0);

        step(0, 1, 0, 0, '0);
        for (int i = 1; i <= 8; i++) px(PIX_W'(i));
        #2 chk("lit_full_done", PAIR_W'(frame_done), 36'h1);
        chk("lit_full_addr", PAIR_W'(write_addr), 36'h3);
        px(18'h00009);
        px(18'h0000A);
        step(0, 0, 1, 0, '0);
        #2 chk("lit_overrun", PAIR_W'(overrun), 36'h1);
        chk("lit_full_no_emit", PAIR_W'(pair_valid), 36'h0);
        step(0, 1, 0, 0, '0);
        #2 chk("lit_overrun_sticky", PAIR_W'(overrun), 36'h1);

        px(18'h00001);
        step(0, 1, 0, 1, 18'h00002);
        px(18'h00003);
        #2 chk("lit_restart_pair", two_pixel_vals, 36'h000080003);
        chk("lit_restart_addr", PAIR_W'(write_addr), 36'h0);
        step(0, 1, 1, 1, 18'h00007);
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
